// File: rtl/mc_infer_ctrl.sv
// Monte Carlo inference sequencer: accepts one input vector, steps the stochastic
// datapath 2^LOG2_NSAMP times, accumulates the outputs and returns their per-output mean.
module mc_infer_ctrl #(
    parameter int W          = 20,
    parameter int NOUT       = 9,
    parameter int LOG2_NSAMP = 3,
    parameter int SETTLE     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8:0]          in_x,
    output logic [8:0]          dp_x,
    output logic                dp_step,
    input  logic [NOUT*W-1:0]   dp_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NOUT*W-1:0]   y_avg,
    output logic                busy
);

    localparam int AW  = W + LOG2_NSAMP;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t                 state, state_nx;
    logic [LOG2_NSAMP-1:0]  samp_cnt;
    logic [SCW-1:0]         settle_cnt;
    logic signed [AW-1:0]   acc     [NOUT];
    logic signed [AW-1:0]   acc_new [NOUT];
    logic [NOUT*W-1:0]      avg_new;
    logic                   last_samp;
    logic                   settle_done;

    assign last_samp   = (samp_cnt == '1);
    assign settle_done = (settle_cnt == SCW'(SETTLE - 1));

    // Accumulators are wide enough for 2^LOG2_NSAMP full-scale samples, so the
    // floor-shifted mean always fits back into W bits.
    always_comb begin
        avg_new = '0;
        for (int i = 0; i < NOUT; i++) begin
            logic signed [AW-1:0] shifted;
            acc_new[i] = acc[i] + $signed({{LOG2_NSAMP{dp_y[i*W+W-1]}}, dp_y[i*W +: W]});
            shifted    = acc_new[i] >>> LOG2_NSAMP;
            avg_new[i*W +: W] = shifted[W-1:0];
        end
    end

    // Both handshakes transfer on a rising edge where valid && ready; in_ready is
    // only asserted in IDLE and out_valid only in DONE, so accept and consume never coincide.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (in_valid) state_nx = S_STEP;
            S_STEP:   state_nx = S_SETTLE;
            S_SETTLE: if (settle_done) state_nx = S_ACC;
            S_ACC:    state_nx = last_samp ? S_DONE : S_STEP;
            S_DONE:   if (out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    assign in_ready  = (state == S_IDLE);
    assign dp_step   = (state == S_STEP);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            dp_x       <= '0;
            y_avg      <= '0;
            samp_cnt   <= '0;
            settle_cnt <= '0;
            for (int i = 0; i < NOUT; i++) acc[i] <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                // dp_x and y_avg deliberately survive an abort
                samp_cnt   <= '0;
                settle_cnt <= '0;
                for (int i = 0; i < NOUT; i++) acc[i] <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            dp_x     <= in_x;
                            samp_cnt <= '0;
                            for (int i = 0; i < NOUT; i++) acc[i] <= '0;
                        end
                    end
                    S_STEP:   settle_cnt <= '0;
                    S_SETTLE: if (!settle_done) settle_cnt <= settle_cnt + 1'b1;
                    S_ACC: begin
                        for (int i = 0; i < NOUT; i++) acc[i] <= acc_new[i];
                        if (last_samp) y_avg <= avg_new;
                        else           samp_cnt <= samp_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc_infer_ctrl.sv
// Scoreboard bench for mc_infer_ctrl: a datapath model feeds per-sample Y tables,
// a monitor checks every returned mean against hand-computed expectations.
module tb_mc_infer_ctrl;

    localparam int W      = 20;
    localparam int NOUT   = 9;
    localparam int L      = 3;
    localparam int SETTLE = 2;
    localparam int NS     = 8;
    localparam int LAT    = NS * (SETTLE + 2);
    localparam int YW     = NOUT * W;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [8:0]    in_x = '0;
    logic [8:0]    dp_x;
    logic          dp_step;
    logic [YW-1:0] dp_y = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [YW-1:0] y_avg;
    logic          busy;

    mc_infer_ctrl #(.W(W), .NOUT(NOUT), .LOG2_NSAMP(L), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .dp_x(dp_x), .dp_step(dp_step), .dp_y(dp_y),
        .out_valid(out_valid), .out_ready(out_ready), .y_avg(y_avg),
        .busy(busy)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            acc_cyc = 0;
    int            step_idx = 0;
    int            last_step = 0;
    logic          prev_ov = 1'b0;
    logic [YW-1:0] exp_q[$];
    logic [YW-1:0] ytab [NS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // datapath model: each dp_step presents the next sample's Y vector
    always @(negedge clk) begin
        if (dp_step === 1'b1) begin
            if (step_idx > 0) check("step_spacing", YW'(cyc - last_step), YW'(SETTLE + 2));
            dp_y      = ytab[step_idx % NS];
            last_step = cyc;
            step_idx++;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            check("latency", YW'(cyc - acc_cyc), YW'(LAT));
            check("step_count", YW'(step_idx), YW'(NS));
        end
        prev_ov = out_valid;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", y_avg);
            end else begin
                check("y_avg", y_avg, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input int mode);
        for (int s = 0; s < NS; s++) begin
            ytab[s] = '0;
            for (int i = 0; i < NOUT; i++) begin
                if (mode == 0) ytab[s][i*W +: W] = 20'h08000;
            end
            if (mode == 1) ytab[s][0 +: W] = W'(16 * s);
            if (mode == 2) begin
                ytab[s][3*W +: W] = (s % 2 == 0) ? 20'hFFFFF : 20'hFFFFE;
                ytab[s][4*W +: W] = 20'h7FFFF;
            end
        end
    endtask

    function automatic logic [YW-1:0] exp_const();
        logic [YW-1:0] e;
        for (int i = 0; i < NOUT; i++) e[i*W +: W] = 20'h08000;
        return e;
    endfunction

    function automatic logic [YW-1:0] exp_ramp();
        logic [YW-1:0] e;
        e = '0;
        e[0 +: W] = 20'd56;
        return e;
    endfunction

    function automatic logic [YW-1:0] exp_neg();
        logic [YW-1:0] e;
        e = '0;
        e[3*W +: W] = 20'hFFFFE;
        e[4*W +: W] = 20'h7FFFF;
        return e;
    endfunction

    task automatic send(input logic [8:0] x, input logic [YW-1:0] exp, input bit push);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("send_timeout", YW'(in_ready), YW'(1));
            return;
        end
        in_valid = 1'b1;
        in_x     = x;
        tick();
        in_valid = 1'b0;
        acc_cyc  = cyc;
        step_idx = 0;
        if (push) exp_q.push_back(exp);
        check("dp_x_latch", YW'(dp_x), YW'(x));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("done_timeout", YW'(exp_q.size()), YW'(0));
    endtask

    task automatic wait_steps(input int k);
        int n;
        n = 0;
        while (step_idx < k && n < 200) begin
            tick();
            n++;
        end
        check("step_wait", YW'(step_idx >= k), YW'(1));
    endtask

    task automatic check_idle(input string tag, input logic [8:0] x_exp);
        check({tag, "_in_ready"}, YW'(in_ready), YW'(1));
        check({tag, "_busy"}, YW'(busy), YW'(0));
        check({tag, "_out_valid"}, YW'(out_valid), YW'(0));
        check({tag, "_dp_step"}, YW'(dp_step), YW'(0));
        check({tag, "_dp_x"}, YW'(dp_x), YW'(x_exp));
    endtask

    initial begin
        logic [YW-1:0] snap;
        int n;
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [YW-1:0] snap;
        int n;
        load_table(0);
        repeat (3) tick();
        check_idle("reset", 9'h000);
        check("reset_y_avg", y_avg, '0);
        reset = 1'b1;
        tick();

        // constant Y
        load_table(0);
        send(9'h1A5, exp_const(), 1'b1);
        wait_done();

        // ramp on Y_0
        load_table(1);
        send(9'h055, exp_ramp(), 1'b1);
        wait_done();

        // negative floor rounding and full-scale positive
        load_table(2);
        send(9'h1FF, exp_neg(), 1'b1);
        wait_done();

        // backpressure in DONE with a competing in_valid
        load_table(0);
        out_ready = 1'b0;
        send(9'h0F3, exp_const(), 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("bp_reach_done", YW'(out_valid), YW'(1));
        snap     = y_avg;
        in_valid = 1'b1;
        in_x     = 9'h111;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_out_valid", YW'(out_valid), YW'(1));
            check("bp_in_ready", YW'(in_ready), YW'(0));
            check("bp_busy", YW'(busy), YW'(1));
            check("bp_dp_x", YW'(dp_x), YW'(9'h0F3));
            check("bp_y_avg", y_avg, snap);
        end
        load_table(1);
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", YW'({in_ready, busy, out_valid}), YW'(3'b100));
        tick();
        in_valid = 1'b0;
        acc_cyc  = cyc;
        step_idx = 0;
        exp_q.push_back(exp_ramp());
        check("bp_next_dp_x", YW'(dp_x), YW'(9'h111));
        check("bp_next_busy", YW'(busy), YW'(1));
        wait_done();

        // reset during SETTLE of sample 4
        load_table(0);
        send(9'h0C3, '0, 1'b0);
        wait_steps(5);
        check("mid_in_settle", YW'({busy, dp_step}), YW'(2'b10));
        reset = 1'b0;
        tick();
        check_idle("midreset", 9'h000);
        check("midreset_y_avg", y_avg, '0);
        reset = 1'b1;
        load_table(2);
        send(9'h1E1, exp_neg(), 1'b1);
        wait_done();

        // flush during ACC of sample 6
        load_table(0);
        send(9'h066, '0, 1'b0);
        wait_steps(7);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush", 9'h066);
        check("flush_y_avg_kept", y_avg, exp_neg());
        // flush wins over in_valid in IDLE
        in_valid = 1'b1;
        in_x     = 9'h0AA;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("flush_prio", 9'h066);
        load_table(1);
        send(9'h0AA, exp_ramp(), 1'b1);
        wait_done();

        repeat (5) tick();
        check("final_queue_empty", YW'(exp_q.size()), YW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_infer_ctrl.md
Name: mc_infer_ctrl

Overview:
Sequencer for the Bayesian inference datapath: 9-bit input X, two stochastic hidden neurons (mean/var/softplus/dev/epsilon), and nine sigmoid output neurons. It accepts one input vector by valid/ready handshake and holds it on the datapath. It then runs 2^LOG2_NSAMP Monte Carlo samples, pulsing the epsilon-advance strobe once per sample and waiting a settle window before each capture. It accumulates the nine Y outputs and returns their per-output mean by valid/ready handshake.

Parameters:
W, 20, width of each signed datapath output Y_i
NOUT, 9, number of output neurons
LOG2_NSAMP, 3, log2 of samples per inference (8 samples)
SETTLE, 2, cycles waited after dp_step before Y is captured (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous abort to IDLE
in_valid  in  1  input vector valid
in_ready  out  1  controller can accept vector
in_x  in  9  input vector, bit 8 = X_0
dp_x  out  9  input vector driven to datapath
dp_step  out  1  one-cycle strobe advancing epsilon generators
dp_y  in  NOUT*W  datapath outputs, Y_i at bits [i*W +: W], signed
out_valid  out  1  averaged result valid
out_ready  in  1  consumer accepts result
y_avg  out  NOUT*W  averaged outputs, same packing as dp_y
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; dp_x=0, dp_step=0, out_valid=0, y_avg=0, all accumulators=0, sample and settle counters=0. Reset overrides flush and all handshakes. Mid-operation reset discards the run.
- States: IDLE, STEP, SETTLE, ACC, DONE.
- IDLE: in_ready=1. If in_valid at the edge: latch in_x into dp_x, clear accumulators and sample count, go to STEP.
- STEP: dp_step=1 for exactly this cycle, settle count cleared, go to SETTLE.
- SETTLE: stay exactly SETTLE cycles, then go to ACC.
- ACC: acc_i += sign-extended Y_i for all i in parallel.
  - If the sample count is 2^LOG2_NSAMP-1: load y_avg_i = acc_i_new >>> LOG2_NSAMP, then go to DONE.
  - Otherwise increment the sample count and go to STEP.
- Accumulator width is W+LOG2_NSAMP and cannot overflow. The shift is arithmetic, so division rounds toward minus infinity. The result always fits in W bits.
- DONE: out_valid=1; y_avg stable. On out_ready at the edge: out_valid goes 0 and the state goes to IDLE. y_avg keeps its value until the next DONE load.
- in_ready is 1 only in IDLE. in_valid in any other state is ignored, with no queueing. A new vector cannot be accepted in the same cycle a result is consumed.
- Each sample takes SETTLE+2 cycles. out_valid rises N*(SETTLE+2) clock edges after the accepting edge, with N=2^LOG2_NSAMP. Defaults give 32 edges.
- dp_x is constant from the accepting edge until the state returns to IDLE. This guarantees X is stable for every sample.
- flush=1 at an edge (reset inactive): go to IDLE, dp_step=0, out_valid=0, accumulators cleared. dp_x and y_avg are retained.
  - flush has priority over in_valid in IDLE, so no vector is accepted that cycle.
  - flush in DONE drops the pending result.
- busy = (state != IDLE).

Test Plan:
- Constant Y_i=20'sh08000 for all i, in_x=9'h1A5 -> dp_x=9'h1A5 after accept; exactly 8 dp_step pulses spaced 4 cycles; out_valid 32 edges after accept; every y_avg_i=20'sh08000.
- Ramp: Y_0 = 16*s for sample s=0..7, other Y=0 -> y_avg_0=56 (sum 448); others 0.
- Negative rounding: Y_3 alternates -1,-2 over 8 samples -> sum -12, y_avg_3=20'shFFFFE (-2, floor); Y_4 max 20'sh7FFFF constant -> 20'sh7FFFF with no overflow.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_valid, y_avg and dp_x stable; in_ready=0, busy=1; out_ready=1 -> IDLE next cycle, then the new vector is accepted.
- reset=0 during SETTLE of sample 4 -> next cycle all outputs 0, IDLE, in_ready=1; a fresh run afterwards gives correct averages.
- flush during ACC of sample 6, then in_valid with a new in_x -> no out_valid for the aborted run; new run produces out_valid 32 edges after its accept, with averages of the new run only.
